// File: rtl/adc_reader.sv
// adc_reader: answers the controller's adc_trig/adc_done handshake by running one
// conversion on a dual-channel 14-bit SPI ADC (LTC1407A-style). It pulses ad_conv,
// clocks 34 SCK periods, captures both channels and returns them with adc_done.
module adc_reader #(
   parameter int unsigned SCK_HALF = 2
) (
   input  logic        CLK50MHZ,
   input  logic        RST,
   input  logic        adc_trig,
   output logic        adc_done,
   output logic [13:0] adc_a,
   output logic [13:0] adc_b,
   output logic        busy,
   output logic        ad_conv,
   output logic        spi_sck,
   input  logic        spi_miso
);

   localparam int unsigned      DIV_W    = $clog2(SCK_HALF) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [5:0]       NUM_BITS = 6'd34;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StShift,
      StDone
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic             sck_q, sck_d;
   logic             conv_q, conv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [13:0]      sh_a_q, sh_a_d;
   logic [13:0]      sh_b_q, sh_b_d;
   logic [13:0]      a_q, a_d;
   logic [13:0]      b_q, b_d;

   logic             div_end;
   logic [5:0]       bit_k;

   // Half-period boundary and the index of the rising edge about to be issued.
   always_comb begin
      div_end = (div_q == DIV_LAST);
      bit_k   = bit_cnt_q + 6'd1;
   end

   // Next-state logic: conversion strobe, SCK generation and data capture.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      sck_d     = sck_q;
      conv_d    = conv_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sh_a_d    = sh_a_q;
      sh_b_d    = sh_b_q;
      a_d       = a_q;
      b_d       = b_q;

      unique case (state_q)
         StIdle: begin
            if (adc_trig) begin
               state_d   = StConv;
               conv_d    = 1'b1;
               busy_d    = 1'b1;
               div_d     = '0;
               bit_cnt_d = '0;
               sh_a_d    = '0;
               sh_b_d    = '0;
            end
         end

         // bit_cnt counts SCK half-periods here: two with ad_conv high, then
         // one settle cycle with ad_conv low before SCK starts.
         StConv: begin
            if (bit_cnt_q == 6'd2) begin
               state_d   = StShift;
               bit_cnt_d = '0;
               div_d     = '0;
            end else if (div_end) begin
               div_d     = '0;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd1) begin
                  conv_d = 1'b0;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end

         StShift: begin
            if (div_end) begin
               div_d = '0;
               if (!sck_q) begin
                  // Rising edge k: MISO was set up on the previous falling edge.
                  sck_d     = 1'b1;
                  bit_cnt_d = bit_k;
                  if (bit_k >= 6'd3 && bit_k <= 6'd16) begin
                     sh_a_d = {sh_a_q[12:0], spi_miso};
                  end else if (bit_k >= 6'd19 && bit_k <= 6'd32) begin
                     sh_b_d = {sh_b_q[12:0], spi_miso};
                  end
               end else begin
                  sck_d = 1'b0;
                  if (bit_cnt_q == NUM_BITS) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     a_d     = sh_a_q;
                     b_d     = sh_b_q;
                  end
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end

         StDone: begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            div_d     = '0;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state_q   <= StIdle;
         div_q     <= '0;
         bit_cnt_q <= '0;
         sck_q     <= 1'b0;
         conv_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sh_a_q    <= '0;
         sh_b_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         sck_q     <= sck_d;
         conv_q    <= conv_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sh_a_q    <= sh_a_d;
         sh_b_q    <= sh_b_d;
         a_q       <= a_d;
         b_q       <= b_d;
      end
   end

   // All outputs come straight from registers.
   always_comb begin
      adc_done = done_q;
      adc_a    = a_q;
      adc_b    = b_q;
      busy     = busy_q;
      ad_conv  = conv_q;
      spi_sck  = sck_q;
   end

endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader: one instance at the default SCK_HALF=2 and one at 1,
// each fed by a small ADC model that shifts a 34-bit frame out on SCK falling edges.
module tb_adc_reader;

   logic        CLK50MHZ = 1'b0;
   logic        RST      = 1'b1;

   logic        adc_trig0 = 1'b0;
   logic        adc_done0;
   logic [13:0] adc_a0, adc_b0;
   logic        busy0, ad_conv0, spi_sck0;
   logic        spi_miso0 = 1'b0;

   logic        adc_trig1 = 1'b0;
   logic        adc_done1;
   logic [13:0] adc_a1, adc_b1;
   logic        busy1, ad_conv1, spi_sck1;
   logic        spi_miso1 = 1'b0;

   int checks = 0;
   int passed = 0;

   adc_reader #(.SCK_HALF(2)) dut0 (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .adc_trig (adc_trig0),
      .adc_done (adc_done0),
      .adc_a    (adc_a0),
      .adc_b    (adc_b0),
      .busy     (busy0),
      .ad_conv  (ad_conv0),
      .spi_sck  (spi_sck0),
      .spi_miso (spi_miso0)
   );

   adc_reader #(.SCK_HALF(1)) dut1 (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .adc_trig (adc_trig1),
      .adc_done (adc_done1),
      .adc_a    (adc_a1),
      .adc_b    (adc_b1),
      .busy     (busy1),
      .ad_conv  (ad_conv1),
      .spi_sck  (spi_sck1),
      .spi_miso (spi_miso1)
   );

   initial forever #5 CLK50MHZ = ~CLK50MHZ;

   // Frame bit 1 is the first bit clocked; discard slots use non-zero patterns.
   function automatic logic [1:34] mk(input logic [13:0] a, input logic [13:0] b);
      mk = {2'b10, a, 2'b01, b, 2'b11};
   endfunction

   // ADC models: frame restarts on ad_conv, next bit presented on each SCK fall.
   logic [1:34] frame0 = '0;
   logic [1:34] frame1 = '0;
   int r0 = 0;
   int r1 = 0;

   always @(posedge ad_conv0) begin
      r0 = 0;
      spi_miso0 = frame0[1];
   end
   always @(negedge spi_sck0) begin
      r0 = r0 + 1;
      if (r0 < 34) spi_miso0 = frame0[r0 + 1];
   end
   always @(posedge ad_conv1) begin
      r1 = 0;
      spi_miso1 = frame1[1];
   end
   always @(negedge spi_sck1) begin
      r1 = r1 + 1;
      if (r1 < 34) spi_miso1 = frame1[r1 + 1];
   end

   // Statistics gathered by run(); cycle i is the one starting i edges after the trigger edge.
   int          st_conv, st_rises, st_bad, st_done, st_done_i, st_busy_gap, st_hold_bad;
   logic        st_conv_first, st_busy_after;
   logic [13:0] st_a, st_b;

   task automatic run(input bit inst, input int h, input int x1, input int x2, input int win);
      logic        sck, prev, cv, dn, bs, t;
      logic [13:0] a, b, la, lb;
      int          hi, lo;
      st_conv = 0; st_rises = 0; st_bad = 0; st_done = 0; st_done_i = -1;
      st_busy_gap = 0; st_hold_bad = 0; st_conv_first = 1'b0; st_busy_after = 1'b1;
      st_a = '0; st_b = '0;
      prev = 1'b0; hi = 0; lo = 0;
      la = inst ? adc_a1 : adc_a0;
      lb = inst ? adc_b1 : adc_b0;
      if (inst) adc_trig1 = 1'b1; else adc_trig0 = 1'b1;
      for (int i = 0; i < win; i++) begin
         @(negedge CLK50MHZ);
         t = (i + 1 == x1) || (i + 1 == x2);
         if (inst) adc_trig1 = t; else adc_trig0 = t;
         sck = inst ? spi_sck1  : spi_sck0;
         cv  = inst ? ad_conv1  : ad_conv0;
         dn  = inst ? adc_done1 : adc_done0;
         bs  = inst ? busy1     : busy0;
         a   = inst ? adc_a1    : adc_a0;
         b   = inst ? adc_b1    : adc_b0;
         if (i == 0) st_conv_first = cv;
         if (cv) st_conv++;
         if (sck) begin
            if (!prev) begin
               st_rises++;
               if (st_rises > 1 && lo != h) st_bad++;
               lo = 0;
            end
            hi++;
         end else begin
            if (prev) begin
               if (hi != h) st_bad++;
               hi = 0;
            end
            lo++;
         end
         prev = sck;
         if (dn) begin
            st_done++;
            st_done_i = i;
            st_a = a;
            st_b = b;
         end else if (a !== la || b !== lb) begin
            st_hold_bad++;
         end
         la = a;
         lb = b;
         if (!bs && st_done == 0) st_busy_gap++;
         if (st_done_i >= 0 && i == st_done_i + 1) st_busy_after = bs;
      end
      adc_trig0 = 1'b0;
      adc_trig1 = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge CLK50MHZ);
      checks++; if (adc_done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", adc_done0); else passed++;
      checks++; if (adc_a0 !== 14'h0) $display("FAIL reset_a: got %h want 0000", adc_a0); else passed++;
      checks++; if (adc_b0 !== 14'h0) $display("FAIL reset_b: got %h want 0000", adc_b0); else passed++;
      checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else passed++;
      checks++; if (ad_conv0 !== 1'b0) $display("FAIL reset_ad_conv: got %b want 0", ad_conv0); else passed++;
      checks++; if (spi_sck0 !== 1'b0) $display("FAIL reset_sck: got %b want 0", spi_sck0); else passed++;
      // Trigger coincident with reset must be lost.
      adc_trig0 = 1'b1;
      @(negedge CLK50MHZ);
      RST = 1'b0;
      adc_trig0 = 1'b0;
      checks++; if (busy0 !== 1'b0) $display("FAIL reset_trig_busy: got %b want 0", busy0); else passed++;
      checks++; if (ad_conv0 !== 1'b0) $display("FAIL reset_trig_conv: got %b want 0", ad_conv0); else passed++;
      repeat (2) @(negedge CLK50MHZ);
   endtask

   task automatic test_basic;
      frame0 = mk(14'h2AAA, 14'h1555);
      run(1'b0, 2, 0, 0, 150);
      checks++; if (st_conv_first !== 1'b1) $display("FAIL basic_conv_edge: got %b want 1", st_conv_first); else passed++;
      checks++; if (st_conv != 4) $display("FAIL basic_conv_len: got %0d want 4", st_conv); else passed++;
      checks++; if (st_rises != 34) $display("FAIL basic_sck_rises: got %0d want 34", st_rises); else passed++;
      checks++; if (st_bad != 0) $display("FAIL basic_sck_shape: got %0d bad phases want 0", st_bad); else passed++;
      checks++; if (st_done != 1) $display("FAIL basic_done_count: got %0d want 1", st_done); else passed++;
      checks++; if (st_done_i != 141) $display("FAIL basic_latency: got %0d want 141", st_done_i); else passed++;
      checks++; if (st_a !== 14'h2AAA) $display("FAIL basic_a: got %h want 2aaa", st_a); else passed++;
      checks++; if (st_b !== 14'h1555) $display("FAIL basic_b: got %h want 1555", st_b); else passed++;
      checks++; if (st_busy_gap != 0) $display("FAIL basic_busy_gap: got %0d want 0", st_busy_gap); else passed++;
      checks++; if (st_busy_after !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", st_busy_after); else passed++;
   endtask

   task automatic test_signed;
      frame0 = mk(14'h2000, 14'h3FFF);
      run(1'b0, 2, 0, 0, 150);
      checks++; if (st_a !== 14'h2000) $display("FAIL signed_a1: got %h want 2000", st_a); else passed++;
      checks++; if (st_b !== 14'h3FFF) $display("FAIL signed_b1: got %h want 3fff", st_b); else passed++;
      repeat (5) @(negedge CLK50MHZ);
      checks++; if (adc_a0 !== 14'h2000 || adc_b0 !== 14'h3FFF)
         $display("FAIL signed_hold_idle: got %h/%h want 2000/3fff", adc_a0, adc_b0); else passed++;
      frame0 = mk(14'h1FFF, 14'h0000);
      run(1'b0, 2, 0, 0, 150);
      checks++; if (st_a !== 14'h1FFF) $display("FAIL signed_a2: got %h want 1fff", st_a); else passed++;
      checks++; if (st_b !== 14'h0000) $display("FAIL signed_b2: got %h want 0000", st_b); else passed++;
      checks++; if (st_hold_bad != 0) $display("FAIL signed_hold: got %0d changes want 0", st_hold_bad); else passed++;
   endtask

   task automatic test_trig_while_busy;
      frame0 = mk(14'h0F0F, 14'h30C3);
      run(1'b0, 2, 20, 140, 160);
      checks++; if (st_done != 1) $display("FAIL busy_done_count: got %0d want 1", st_done); else passed++;
      checks++; if (st_rises != 34) $display("FAIL busy_sck_rises: got %0d want 34", st_rises); else passed++;
      checks++; if (st_busy_gap != 0) $display("FAIL busy_gap: got %0d want 0", st_busy_gap); else passed++;
      checks++; if (st_busy_after !== 1'b0) $display("FAIL busy_fall: got %b want 0", st_busy_after); else passed++;
      checks++; if (st_a !== 14'h0F0F) $display("FAIL busy_a: got %h want 0f0f", st_a); else passed++;
   endtask

   task automatic test_back_to_back;
      frame0 = mk(14'h1234, 14'h2345);
      run(1'b0, 2, 0, 0, 142);
      checks++; if (st_done_i != 141) $display("FAIL b2b_first_done: got %0d want 141", st_done_i); else passed++;
      @(negedge CLK50MHZ);
      checks++; if (busy0 !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy0); else passed++;
      frame0 = mk(14'h3456, 14'h0567);
      run(1'b0, 2, 0, 0, 150);
      checks++; if (st_conv_first !== 1'b1) $display("FAIL b2b_conv_edge: got %b want 1", st_conv_first); else passed++;
      checks++; if (st_done_i != 141) $display("FAIL b2b_second_done: got %0d want 141", st_done_i); else passed++;
      checks++; if (st_a !== 14'h3456 || st_b !== 14'h0567)
         $display("FAIL b2b_data: got %h/%h want 3456/0567", st_a, st_b); else passed++;
   endtask

   task automatic test_reset_mid_shift;
      int dones;
      frame0 = mk(14'h0123, 14'h0456);
      run(1'b0, 2, 0, 0, 150);
      checks++; if (st_a !== 14'h0123) $display("FAIL rst_pre_a: got %h want 0123", st_a); else passed++;
      frame0 = mk(14'h3ABC, 14'h1DEF);
      adc_trig0 = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK50MHZ);
         adc_trig0 = 1'b0;
         if (i == 59) RST = 1'b1;
      end
      @(negedge CLK50MHZ);
      RST = 1'b0;
      checks++; if (spi_sck0 !== 1'b0) $display("FAIL rst_mid_sck: got %b want 0", spi_sck0); else passed++;
      checks++; if (ad_conv0 !== 1'b0) $display("FAIL rst_mid_conv: got %b want 0", ad_conv0); else passed++;
      checks++; if (busy0 !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy0); else passed++;
      checks++; if (adc_a0 !== 14'h0 || adc_b0 !== 14'h0)
         $display("FAIL rst_mid_data: got %h/%h want 0000/0000", adc_a0, adc_b0); else passed++;
      dones = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge CLK50MHZ);
         if (adc_done0) dones++;
      end
      checks++; if (dones != 0) $display("FAIL rst_mid_no_done: got %0d want 0", dones); else passed++;
      frame0 = mk(14'h2468, 14'h1357);
      run(1'b0, 2, 0, 0, 150);
      checks++; if (st_done_i != 141) $display("FAIL rst_after_latency: got %0d want 141", st_done_i); else passed++;
      checks++; if (st_a !== 14'h2468 || st_b !== 14'h1357)
         $display("FAIL rst_after_data: got %h/%h want 2468/1357", st_a, st_b); else passed++;
   endtask

   task automatic test_sck_half_1;
      frame1 = mk(14'h3A5C, 14'h05A3);
      run(1'b1, 1, 0, 0, 80);
      checks++; if (st_conv != 2) $display("FAIL h1_conv_len: got %0d want 2", st_conv); else passed++;
      checks++; if (st_rises != 34) $display("FAIL h1_sck_rises: got %0d want 34", st_rises); else passed++;
      checks++; if (st_bad != 0) $display("FAIL h1_sck_shape: got %0d bad phases want 0", st_bad); else passed++;
      checks++; if (st_done != 1) $display("FAIL h1_done_count: got %0d want 1", st_done); else passed++;
      checks++; if (st_done_i != 71) $display("FAIL h1_latency: got %0d want 71", st_done_i); else passed++;
      checks++; if (st_a !== 14'h3A5C || st_b !== 14'h05A3)
         $display("FAIL h1_data: got %h/%h want 3a5c/05a3", st_a, st_b); else passed++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signed;
      test_trig_while_busy;
      test_back_to_back;
      test_reset_mid_shift;
      test_sck_half_1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
